// File: rtl/multicycle_control_if.sv
// multicycle_control_if: control, memory-handshake and status signals between
// the multicycle controller (master) and the RV64I datapath (slave).
interface multicycle_control_if #(parameter int COUNT_W = 32);
    logic [4:0]         OpCode;
    logic               MemReady;
    logic               MemValid;
    logic               MemWrite;
    logic               IorD;
    logic               IRWrite;
    logic               PCWrite;
    logic               PCWriteCond;
    logic               PCSrc;
    logic [1:0]         ALUSrcA;
    logic [1:0]         ALUSrcB;
    logic [1:0]         ALUOp;
    logic               RegWrite;
    logic               MemToReg;
    logic               Trap;
    logic [1:0]         TrapCause;
    logic [COUNT_W-1:0] Retired;
    modport master (
        input  OpCode, MemReady,
        output MemValid, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSrc,
               ALUSrcA, ALUSrcB, ALUOp, RegWrite, MemToReg, Trap, TrapCause, Retired
    );
    modport slave (
        output OpCode, MemReady,
        input  MemValid, MemWrite, IorD, IRWrite, PCWrite, PCWriteCond, PCSrc,
               ALUSrcA, ALUSrcB, ALUOp, RegWrite, MemToReg, Trap, TrapCause, Retired
    );
endinterface

// File: rtl/multicycle_control.sv
// multicycle_control: FETCH/DECODE/EXEC/MEM/WB sequencer for the RV64I multicycle
// datapath with memory handshake, watchdog trap, illegal-opcode trap and retire counter.
module multicycle_control #(
    parameter int COUNT_W = 32,
    parameter int TIMEOUT = 255
) (
    input logic                  clk,
    input logic                  rst,
    multicycle_control_if.master bus
);
    localparam int WAIT_W = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [4:0] OP_R  = 5'b01100;
    localparam logic [4:0] OP_I  = 5'b00100;
    localparam logic [4:0] OP_LD = 5'b00000;
    localparam logic [4:0] OP_ST = 5'b01000;
    localparam logic [4:0] OP_BR = 5'b11000;

    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEMADDR, MEMACC, WB, BRANCH, TRAP} state_t;

    state_t             state_q, state_d;
    logic [1:0]         cause_q, cause_d;
    logic [WAIT_W-1:0]  wait_q, wait_d;
    logic [COUNT_W-1:0] retired_q;
    logic               retire, mem_wait, timeout;

    // The counter reaches TIMEOUT on this cycle; a simultaneous MemReady wins.
    assign mem_wait = (state_q == FETCH || state_q == MEMACC) && !bus.MemReady;
    assign timeout  = TIMEOUT != 0 && mem_wait && wait_q == WAIT_W'(TIMEOUT - 1);
    assign wait_d   = (state_d != state_q || bus.MemReady) ? '0 : wait_q + WAIT_W'(mem_wait);

    assign bus.Trap      = !rst && state_q == TRAP;
    assign bus.TrapCause = rst ? 2'b00 : cause_q;
    assign bus.Retired   = rst ? '0 : retired_q;

    always_comb begin
        state_d         = state_q;
        cause_d         = cause_q;
        retire          = 1'b0;
        bus.MemValid    = 1'b0;
        bus.MemWrite    = 1'b0;
        bus.IorD        = 1'b0;
        bus.IRWrite     = 1'b0;
        bus.PCWrite     = 1'b0;
        bus.PCWriteCond = 1'b0;
        bus.PCSrc       = 1'b0;
        bus.ALUSrcA     = 2'b00;
        bus.ALUSrcB     = 2'b00;
        bus.ALUOp       = 2'b00;
        bus.RegWrite    = 1'b0;
        bus.MemToReg    = 1'b0;
        if (!rst) begin
            case (state_q)
                FETCH: begin
                    bus.MemValid = 1'b1;
                    if (bus.MemReady) begin
                        bus.IRWrite = 1'b1;
                        bus.PCWrite = 1'b1;
                        bus.ALUSrcB = 2'b01;
                        state_d     = DECODE;
                    end
                end
                DECODE: begin
                    bus.ALUSrcA = 2'b10;
                    bus.ALUSrcB = 2'b10;
                    state_d = (bus.OpCode == OP_R || bus.OpCode == OP_I) ? EXEC :
                              (bus.OpCode == OP_LD || bus.OpCode == OP_ST) ? MEMADDR :
                              bus.OpCode == OP_BR ? BRANCH : TRAP;
                    cause_d = state_d == TRAP ? 2'b01 : cause_q;
                end
                EXEC: begin
                    bus.ALUSrcA = 2'b01;
                    bus.ALUSrcB = bus.OpCode == OP_I ? 2'b10 : 2'b00;
                    bus.ALUOp   = 2'b10;
                    state_d     = WB;
                end
                MEMADDR: begin
                    bus.ALUSrcA = 2'b01;
                    bus.ALUSrcB = 2'b10;
                    state_d     = MEMACC;
                end
                MEMACC: begin
                    bus.MemValid = 1'b1;
                    bus.IorD     = 1'b1;
                    bus.MemWrite = bus.OpCode == OP_ST;
                    if (bus.MemReady) begin
                        retire  = bus.OpCode == OP_ST;
                        state_d = bus.OpCode == OP_ST ? FETCH : WB;
                    end
                end
                WB: begin
                    bus.RegWrite = 1'b1;
                    bus.MemToReg = bus.OpCode == OP_LD;
                    retire       = 1'b1;
                    state_d      = FETCH;
                end
                BRANCH: begin
                    bus.ALUSrcA     = 2'b01;
                    bus.ALUOp       = 2'b01;
                    bus.PCWriteCond = 1'b1;
                    bus.PCSrc       = 1'b1;
                    retire          = 1'b1;
                    state_d         = FETCH;
                end
                default: state_d = TRAP;
            endcase
            if (timeout) begin
                state_d = TRAP;
                cause_d = 2'b10;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            cause_q   <= 2'b00;
            wait_q    <= '0;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            cause_q   <= cause_d;
            wait_q    <= wait_d;
            retired_q <= retired_q + COUNT_W'(retire);
        end
    end
endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multi-cycle main controller for the RV64I core datapath (register file, ALU, ImmGen, unified memory port).
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK states from the 5-bit opcode (instruction bits 6:2, the same OpCode field that drives ImmGen).
- Handles the memory request/ready handshake and memory timeouts.
- Traps on illegal opcodes and counts retired instructions.

Parameters:
- COUNT_W, 32: width of the retired-instruction counter.
- TIMEOUT, 255: maximum cycles to wait for MemReady before a trap; 0 disables the watchdog.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- OpCode  in  5  instruction bits 6:2 taken from the instruction register.
- MemReady  in  1  memory completes the current request this cycle.
- MemValid  out  1  memory request active.
- MemWrite  out  1  request is a write (store); 0 means read.
- IorD  out  1  address select: 0 = PC, 1 = ALUOut.
- IRWrite  out  1  load the instruction register and the OldPC register.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load gated by the datapath Zero flag.
- PCSrc  out  1  PC source: 0 = live ALU result, 1 = ALUOut register.
- ALUSrcA  out  2  ALU operand A: 00 = PC, 01 = rs1, 10 = OldPC.
- ALUSrcB  out  2  ALU operand B: 00 = rs2, 01 = constant 4, 10 = Imm.
- ALUOp  out  2  ALU operation: 00 = add, 01 = subtract/compare, 10 = funct-decoded.
- RegWrite  out  1  register-file write enable.
- MemToReg  out  1  write-back source: 0 = ALUOut, 1 = MDR.
- Trap  out  1  sticky: controller halted.
- TrapCause  out  2  01 = illegal opcode, 10 = memory timeout, 00 = none.
- Retired  out  COUNT_W  retired-instruction count.

Behaviour:
- Reset (already decided):
  - One clock; rst is synchronous and active-high.
  - While rst is high: State=FETCH, Retired=0, Trap=0, TrapCause=00, wait counter=0, and every control output is forced to 0.
  - The first cycle after rst falls is a FETCH.
  - rst mid-instruction abandons the instruction with no retire.
- State register: 3 bits, encoded FETCH=0, DECODE=1, EXEC=2, MEMADDR=3, MEMACC=4, WB=5, BRANCH=6, TRAP=7.
- Output timing: outputs are combinational from State and MemReady (Moore plus ready qualification). Any output not listed for a state is 0.
- FETCH:
  - MemValid=1, IorD=0.
  - If MemReady: IRWrite=1, PCWrite=1, PCSrc=0, ALUSrcA=00, ALUSrcB=01, ALUOp=00, then go to DECODE.
  - Otherwise stay in FETCH.
- DECODE:
  - ALUSrcA=10, ALUSrcB=10, ALUOp=00; ALUOut captures the branch target.
  - Next state by OpCode:
    - 01100 (R-type) or 00100 (I-ALU): EXEC.
    - 00000 (load) or 01000 (store): MEMADDR.
    - 11000 (branch): BRANCH.
    - Any other value: TRAP with TrapCause=01.
- EXEC:
  - ALUSrcA=01, ALUOp=10.
  - ALUSrcB=00 for 01100, 10 for 00100.
  - Go to WB.
- MEMADDR: ALUSrcA=01, ALUSrcB=10, ALUOp=00; go to MEMACC.
- MEMACC:
  - MemValid=1, IorD=1, MemWrite=1 when OpCode=01000.
  - On MemReady: a store retires and goes to FETCH; a load goes to WB.
  - Otherwise stay in MEMACC.
- WB:
  - RegWrite=1; MemToReg=1 for a load, 0 otherwise.
  - Retire the instruction; go to FETCH.
- BRANCH:
  - ALUSrcA=01, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSrc=1.
  - Retire the instruction (taken or not); go to FETCH.
- TRAP:
  - Absorbing; all strobes 0, Trap=1.
  - Only rst exits.
- Latency with zero-wait memory:
  - R-type/I-ALU: 4 cycles.
  - Load: 5 cycles.
  - Store: 4 cycles.
  - Branch: 3 cycles.
  - Each memory wait cycle adds 1.
- Retire counting:
  - Retired increments by 1 on the cycle leaving WB, BRANCH, or a MEMACC store with MemReady.
  - Wraps modulo 2^COUNT_W.
- Memory handshake:
  - MemValid stays high and the address/MemWrite stay stable until MemReady.
  - MemReady while MemValid is low is ignored.
- Watchdog:
  - The wait counter clears on entry to FETCH/MEMACC and on MemReady, and increments each cycle MemValid=1 without MemReady.
  - When the counter reaches TIMEOUT (TIMEOUT>0) without MemReady: go to TRAP, TrapCause=10.
  - MemReady in the same cycle the counter reaches TIMEOUT wins; no trap.
- OpCode is only sampled in DECODE and later states. The IR is stable after FETCH, so OpCode changes during FETCH are don't-care.

Test Plan:
- Reset release, MemReady always 1, OpCode=01100 → states 0,1,2,5,0; RegWrite=1 in cycle 4 only; Retired=1 after cycle 4.
- Load OpCode=00000, MemReady low for 3 cycles in MemAcc → states 0,1,3,4,4,4,4,5; MemToReg=1 in WB; IorD=1 throughout MEMACC; 8 cycles total.
- Store OpCode=01000, zero-wait → MemWrite=1 only in MEMACC; RegWrite never 1; Retired increments on MEMACC exit; 4 cycles.
- Branch OpCode=11000 → DECODE drives ALUSrcA=10, ALUSrcB=10; BRANCH drives PCWriteCond=1, PCSrc=1, ALUOp=01; 3 cycles.
- Illegal OpCode=11111 → TRAP after DECODE; Trap=1, TrapCause=01; stays there for 100 cycles of no strobes; rst returns to FETCH with Retired=0.
- TIMEOUT=4, MemReady held low in FETCH → TRAP, TrapCause=10 after 4 wait cycles; repeat with MemReady on the 4th cycle → no trap, goes to DECODE; TIMEOUT=0 with 1000 wait cycles → no trap.
